// File: rtl/spi_master_cfg.sv
// SPI master with per-transfer CPOL/CPHA, SCLK divider and chip select; one full-duplex WIDTH-bit word per request.
// Optional feature: define SPI_MASTER_CFG_LOOPBACK_EN to add a `loopback` input (internal mosi->sample path, no cs_n).
module spi_master_cfg #(
  parameter int WIDTH  = 8,
  parameter int NUM_CS = 1,
  parameter int DIV_W  = 8,
  localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  div,
  input  logic [CSW-1:0]    cs_sel,
`ifdef SPI_MASTER_CFG_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [WIDTH-1:0]  rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int EW = $clog2(2 * WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * WIDTH - 1);
  localparam logic [CSW:0] NUM_CS_L = (CSW + 1)'(NUM_CS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t            state_r, state_next_s;
  logic [DIV_W:0]    cnt_r;
  logic [EW-1:0]     edge_r;
  logic [DIV_W-1:0]  div_r;
  logic              cpha_r;
  logic [WIDTH-1:0]  tx_sh_r, rx_sh_r, rx_data_r;
  logic [NUM_CS-1:0] cs_n_r, cs_dec_s;
  logic              sclk_r, mosi_r, rx_valid_r, busy_r, tx_ready_r;
  logic              accept_s, step_done_s, edge_s, last_edge_s, sample_s, shift_s;
  logic              sample_bit_s, lb_in_s;

  assign accept_s    = tx_valid && tx_ready_r;
  assign step_done_s = (cnt_r == {1'b0, div_r});
  assign edge_s      = step_done_s && ((state_r == ST_SETUP) || (state_r == ST_XFER));
  assign last_edge_s = (edge_r == LAST_EDGE);
  // edge_r is even on leading edges; sample edge is leading for CPHA=0, trailing for CPHA=1
  assign sample_s    = edge_s && (~edge_r[0] ^ cpha_r);
  assign shift_s     = edge_s && !(~edge_r[0] ^ cpha_r) && (edge_r != '0) && !last_edge_s;

`ifdef SPI_MASTER_CFG_LOOPBACK_EN
  logic lb_r;
  assign lb_in_s      = loopback;
  assign sample_bit_s = lb_r ? mosi_r : miso;

  // Loopback mode latched at accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_r <= 1'b0;
    end else if (accept_s) begin
      lb_r <= loopback;
    end else begin
      lb_r <= lb_r;
    end
  end
`else
  assign lb_in_s      = 1'b0;
  assign sample_bit_s = miso;
`endif

  // Chip-select pattern for the requested slave; out-of-range selects none
  always_comb begin
    cs_dec_s = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (({1'b0, cs_sel} < NUM_CS_L) && (cs_sel == CSW'(i)) && !lb_in_s) begin
        cs_dec_s[i] = 1'b0;
      end else begin
        cs_dec_s[i] = 1'b1;
      end
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_SETUP;
        else          state_next_s = ST_IDLE;
      end
      ST_SETUP: begin
        if (step_done_s) state_next_s = ST_XFER;
        else             state_next_s = ST_SETUP;
      end
      ST_XFER: begin
        if (step_done_s && last_edge_s) state_next_s = ST_HOLD;
        else                            state_next_s = ST_XFER;
      end
      ST_HOLD: begin
        if (step_done_s) state_next_s = ST_GAP;
        else             state_next_s = ST_HOLD;
      end
      ST_GAP: begin
        if (step_done_s) state_next_s = ST_IDLE;
        else             state_next_s = ST_GAP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Datapath: phase counter, shift registers and registered pin/handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= '0;
      edge_r     <= '0;
      div_r      <= '0;
      cpha_r     <= 1'b0;
      tx_sh_r    <= '0;
      rx_sh_r    <= '0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      cs_n_r     <= '1;
      busy_r     <= 1'b0;
      tx_ready_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      busy_r     <= (state_next_s != ST_IDLE);
      tx_ready_r <= (state_next_s == ST_IDLE);
      if ((state_r == ST_IDLE) || step_done_s) cnt_r <= '0;
      else                                     cnt_r <= cnt_r + (DIV_W + 1)'(1);
      case (state_r)
        ST_IDLE: begin
          sclk_r <= cpol;
          if (accept_s) begin
            div_r   <= div;
            cpha_r  <= cpha;
            tx_sh_r <= tx_data;
            rx_sh_r <= '0;
            edge_r  <= '0;
            mosi_r  <= tx_data[WIDTH-1];
            cs_n_r  <= cs_dec_s;
          end else begin
            mosi_r <= 1'b0;
            cs_n_r <= '1;
          end
        end
        ST_SETUP, ST_XFER: begin
          if (edge_s) begin
            sclk_r <= ~sclk_r;
            edge_r <= edge_r + EW'(1);
          end
          if (sample_s) rx_sh_r <= {rx_sh_r[WIDTH-2:0], sample_bit_s};
          if (shift_s) begin
            mosi_r  <= tx_sh_r[WIDTH-2];
            tx_sh_r <= {tx_sh_r[WIDTH-2:0], 1'b0};
          end
        end
        ST_HOLD: begin
          if (step_done_s) begin
            cs_n_r     <= '1;
            mosi_r     <= 1'b0;
            rx_data_r  <= rx_sh_r;
            rx_valid_r <= 1'b1;
          end
        end
        ST_GAP: begin
          cs_n_r <= '1;
        end
        default: begin
          cs_n_r <= '1;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_r;
  assign busy     = busy_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign sclk     = sclk_r;
  assign mosi     = mosi_r;
  assign cs_n     = cs_n_r;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Randomized bench for spi_master_cfg: behavioural SPI slave plus timing/cs expectations from the transfer rules.
module tb_spi_master_cfg;

  localparam int W   = 8;
  localparam int NCS = 5;
  localparam int DW  = 8;
  localparam int CSW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   tx_data = '0;
  logic           tx_valid = 1'b0;
  logic           cpol = 1'b0;
  logic           cpha = 1'b0;
  logic [DW-1:0]  div = '0;
  logic [CSW-1:0] cs_sel = '0;
  logic           miso = 1'b0;
  logic           tx_ready, rx_valid, busy, sclk, mosi;
  logic [W-1:0]   rx_data;
  logic [NCS-1:0] cs_n;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  spi_master_cfg #(.WIDTH(W), .NUM_CS(NCS), .DIV_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .cpol     (cpol),
    .cpha     (cpha),
    .div      (div),
    .cs_sel   (cs_sel),
`ifdef SPI_MASTER_CFG_LOOPBACK_EN
    .loopback (1'b0),
`endif
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural SPI slave: shifts out sl_word, collects mosi, mode taken when busy rises
  logic [W-1:0] sl_word = '0;
  logic [W-1:0] sl_tx = '0;
  logic [W-1:0] sl_rx = '0;
  logic         sl_act = 1'b0;
  logic         sl_cpha = 1'b0;
  int           sl_edges = 0;
  logic         prev_sclk = 1'b0;
  logic         prev_busy = 1'b0;

  function automatic logic next_bit(input logic [W-1:0] w, input int e, input logic pha);
    int b;
    b = pha ? e / 2 : e / 2 + 1;
    if (b < W) return w[W-1-b];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    prev_sclk <= sclk;
    prev_busy <= busy;
    if (rst) begin
      sl_act <= 1'b0;
      miso   <= 1'b0;
    end else if (busy && !prev_busy) begin
      sl_act   <= 1'b1;
      sl_edges <= 0;
      sl_cpha  <= cpha;
      sl_tx    <= sl_word;
      sl_rx    <= '0;
      miso     <= sl_word[W-1];
    end else if (sl_act && (sclk !== prev_sclk)) begin
      sl_edges <= sl_edges + 1;
      if (sl_edges == 2 * W - 1) sl_act <= 1'b0;
      if (((sl_edges % 2) == 0) ^ sl_cpha) sl_rx <= {sl_rx[W-2:0], mosi};
      else miso <= next_bit(sl_tx, sl_edges, sl_cpha);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("ready_wait", tx_ready, 1);
  endtask

  // One transfer, checked against slave data, cs pattern and the edge/result timing formulas
  task automatic run_xfer(input logic [W-1:0] tx, input logic [W-1:0] sw, input logic pol,
                          input logic pha, input logic [DW-1:0] dv, input logic [CSW-1:0] sel);
    int h, t0, n, limit, edges, first_edge, rx_cyc, rx_cnt, rdy_cyc;
    logic [NCS-1:0] exp_cs;
    logic [W-1:0] got_rx;
    logic last_sclk, cs_bad;
    h = int'(dv) + 1;
    limit = (2 * W + 3) * h + 20;
    for (int i = 0; i < NCS; i++) exp_cs[i] = (i == int'(sel)) ? 1'b0 : 1'b1;
    @(negedge clk);
    cpol = pol; cpha = pha; div = dv; cs_sel = sel; tx_data = tx; sl_word = sw;
    repeat (2) @(negedge clk);
    wait_ready();
    chk_eq("idle_sclk", sclk, pol);
    tx_valid = 1'b1;
    t0 = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
    chk_eq("cs_assert", cs_n, exp_cs);
    chk_eq("busy_on", busy, 1);
    chk_eq("mosi_msb", mosi, tx[W-1]);
    last_sclk = pol; edges = 0; first_edge = -1; rx_cyc = -1; rx_cnt = 0; rdy_cyc = -1;
    cs_bad = 1'b0; got_rx = '0; n = 0;
    while (rdy_cyc < 0 && n < limit) begin
      if (sclk !== last_sclk) begin
        edges++;
        if (first_edge < 0) first_edge = cyc;
      end
      last_sclk = sclk;
      if (rx_valid) begin
        rx_cnt++;
        rx_cyc = cyc;
        got_rx = rx_data;
      end
      if (rx_cyc < 0 && cs_n !== exp_cs) cs_bad = 1'b1;
      if (rx_cyc >= 0 && cs_n !== '1) cs_bad = 1'b1;
      if (tx_ready) rdy_cyc = cyc;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk_eq("sclk_edges", edges, 2 * W);
    chk_eq("sclk_rest", sclk, pol);
    chk_eq("edge0_time", first_edge, t0 + 1 + h);
    chk_eq("rx_time", rx_cyc, t0 + 1 + (2 * W + 1) * h);
    chk_eq("rx_pulses", rx_cnt, 1);
    chk_eq("rx_data", got_rx, sw);
    chk_eq("slave_rx", sl_rx, tx);
    chk_eq("ready_time", rdy_cyc, t0 + 1 + (2 * W + 2) * h);
    chk_eq("cs_stable", cs_bad, 0);
    chk_eq("busy_off", busy, 0);
  endtask

  // Two words with tx_valid held high: check both results and the cs_n high gap
  task automatic back_to_back(input logic [W-1:0] w1, input logic [W-1:0] s1,
                              input logic [W-1:0] w2, input logic [W-1:0] s2, input logic [DW-1:0] dv);
    int h, t0, t1, n, nrx, hi_start, lo_again;
    int rx_cyc[2];
    logic [W-1:0] rx_val[2];
    logic [W-1:0] sl_first;
    logic was_low;
    h = int'(dv) + 1;
    t1 = -1; n = 0; nrx = 0; hi_start = -1; lo_again = -1; sl_first = '0;
    rx_cyc[0] = -1; rx_cyc[1] = -1; rx_val[0] = '0; rx_val[1] = '0;
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; div = dv; cs_sel = 3'd1; tx_data = w1; sl_word = s1;
    repeat (2) @(negedge clk);
    wait_ready();
    tx_valid = 1'b1;
    t0 = cyc;
    repeat (2) @(negedge clk);
    tx_data = w2; sl_word = s2;
    was_low = 1'b1;
    while (nrx < 2 && n < 4 * (2 * W + 3) * h + 40) begin
      if (cs_n[1] && was_low && hi_start < 0) hi_start = cyc;
      if (!cs_n[1] && hi_start >= 0 && lo_again < 0) lo_again = cyc;
      was_low = !cs_n[1];
      if (t1 >= 0 && cyc == t1 + 1) tx_valid = 1'b0;
      if (tx_ready && t1 < 0) t1 = cyc;
      if (rx_valid) begin
        rx_cyc[nrx] = cyc;
        rx_val[nrx] = rx_data;
        if (nrx == 0) sl_first = sl_rx;
        nrx++;
      end
      if (nrx < 2) begin
        @(negedge clk);
        n++;
      end
    end
    tx_valid = 1'b0;
    chk_eq("b2b_rx0", rx_val[0], s1);
    chk_eq("b2b_rx1", rx_val[1], s2);
    chk_eq("b2b_slave0", sl_first, w1);
    chk_eq("b2b_slave1", sl_rx, w2);
    chk_eq("b2b_accept2", t1, t0 + 1 + (2 * W + 2) * h);
    chk_eq("b2b_cs_gap", lo_again - hi_start, h + 1);
    chk_eq("b2b_rx1_time", rx_cyc[1], t1 + 1 + (2 * W + 1) * h);
  endtask

  // Reset asserted once edge 5 is visible: outputs drop asynchronously, no result follows
  task automatic reset_abort();
    int edges, n, rx_seen;
    logic last;
    edges = 0; n = 0; rx_seen = 0;
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b0; div = 8'd1; cs_sel = 3'd0; tx_data = 8'h77; sl_word = 8'h11;
    repeat (2) @(negedge clk);
    wait_ready();
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    last = 1'b1;
    while (edges < 6 && n < 200) begin
      if (sclk !== last) edges++;
      last = sclk;
      if (edges < 6) begin
        @(negedge clk);
        n++;
      end
    end
    chk_eq("abort_edge5", edges, 6);
    chk_eq("abort_cs_low", cs_n, 32'h0000_001E);
    rst = 1'b1;
    #1;
    chk_eq("abort_cs_n", cs_n, 32'h0000_001F);
    chk_eq("abort_sclk", sclk, 0);
    chk_eq("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("abort_ready_lo", tx_ready, 0);
    @(negedge clk);
    chk_eq("abort_ready_hi", tx_ready, 1);
    repeat (60) begin
      @(negedge clk);
      if (rx_valid) rx_seen++;
    end
    chk_eq("abort_no_rx", rx_seen, 0);
  endtask

  initial begin
    logic [W-1:0] rtx, rsw;
    repeat (3) @(negedge clk);
    chk_eq("rst_sclk", sclk, 0);
    chk_eq("rst_mosi", mosi, 0);
    chk_eq("rst_cs_n", cs_n, 32'h0000_001F);
    chk_eq("rst_rx_data", rx_data, 0);
    chk_eq("rst_rx_valid", rx_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_tx_ready", tx_ready, 0);
    rst = 1'b0;
    #1;
    chk_eq("rel_ready_lo", tx_ready, 0);
    @(negedge clk);
    chk_eq("rel_ready_hi", tx_ready, 1);

    run_xfer(8'hA5, 8'h5A, 1'b0, 1'b0, 8'd1, 3'd0);
    run_xfer(8'h3C, 8'hC3, 1'b0, 1'b1, 8'd1, 3'd1);
    run_xfer(8'h3C, 8'hC3, 1'b1, 1'b0, 8'd1, 3'd2);
    run_xfer(8'h3C, 8'hC3, 1'b1, 1'b1, 8'd1, 3'd3);
    run_xfer(8'hEF, 8'h34, 1'b0, 1'b0, 8'd0, 3'd4);
    run_xfer(8'h81, 8'h7E, 1'b0, 1'b1, 8'd0, 3'd2);
    run_xfer(8'h0F, 8'hF0, 1'b1, 1'b0, 8'd2, 3'd5);
    run_xfer(8'hC6, 8'h39, 1'b0, 1'b0, 8'hFF, 3'd7);
    for (int k = 0; k < 14; k++) begin
      rtx = W'($urandom);
      rsw = W'($urandom);
      run_xfer(rtx, rsw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               DW'($urandom_range(0, 3)), CSW'($urandom_range(0, 7)));
    end
    back_to_back(8'h12, 8'hED, 8'hB7, 8'h48, 8'd1);
    back_to_back(8'h55, 8'hAA, 8'h01, 8'h80, 8'd0);
    reset_abort();
    run_xfer(8'h96, 8'h69, 1'b0, 1'b0, 8'd1, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
